core_wb_pipelined_master: RTL and testbench

//  Pipelined Wishbone B4 master between the core memory port and the SoC bus. Next generation of the single-transfer core bus interface.

---
 rtl/core_wb_pipelined_master.sv | 234 +++++++++++++++++++++++
 tb/tb_core_wb_pipelined_master.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_wb_pipelined_master.sv
// Pipelined Wishbone B4 master between the core memory port and the SoC bus.
// Keeps up to MAX_OUTSTANDING transfers in flight. This count covers the pending strobe,
// the issued-but-unretired transfers and the buffered responses. Transfers issue on
// stb && !stall. Each ack or error retires the oldest transfer. Responses are buffered
// in order in a show-ahead FIFO. A bus error or a timeout aborts, and every remaining
// transfer then returns as an error response.
// Ports:
//   wb_clk_i, wb_rst_n_i           clock, async active-low reset
//   wb_cyc_o .. wb_data_o          Wishbone master outputs
//   wb_ack_i .. wb_data_i          Wishbone slave responses
//   req_*                          core request channel (valid/ready)
//   rsp_*                          core response channel (valid/ready)
//   busy_o                         anything issued, pending or buffered
//   timeout_o                      one-cycle pulse when a timeout abort starts
module core_wb_pipelined_master #(
  parameter int unsigned ADDRESS_WIDTH   = 28,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255,
  localparam int unsigned SEL_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [SEL_WIDTH-1:0]     wb_sel_o,
  output logic [ADDRESS_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0]    wb_data_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_stall_i,
  input  logic                     wb_error_i,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_write_i,
  input  logic [ADDRESS_WIDTH-1:0] req_address_i,
  input  logic [SEL_WIDTH-1:0]     req_byte_select_i,
  input  logic [DATA_WIDTH-1:0]    req_data_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DATA_WIDTH-1:0]    rsp_data_o,
  output logic                     rsp_error_o,
  output logic                     busy_o,
  output logic                     timeout_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IW = CW + 1;
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PtrLast  = PW'(MAX_OUTSTANDING - 1);
  localparam logic [TW-1:0] TmoLimit = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StActive, StAbort} state_e;

  state_e                   state_q, state_d;
  logic                     stb_q, stb_d;
  logic                     we_q;
  logic [SEL_WIDTH-1:0]     sel_q;
  logic [ADDRESS_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [CW-1:0]            out_q, out_d;
  logic [TW-1:0]            tmo_q, tmo_d;

  logic [DATA_WIDTH-1:0]    fifo_data_q [MAX_OUTSTANDING];
  logic                     fifo_err_q  [MAX_OUTSTANDING];
  logic [PW-1:0]            fifo_wptr_q, fifo_rptr_q;
  logic [CW-1:0]            fifo_cnt_q;

  // Read/write kind of each issued transfer, oldest at ord_rptr_q.
  logic                     ord_we_q [MAX_OUTSTANDING];
  logic [PW-1:0]            ord_wptr_q, ord_rptr_q;

  logic [IW-1:0]            inflight;
  logic                     accept, issue, retire, head_we, timeout_hit, go_abort;
  logic                     push, pop, push_err;
  logic [DATA_WIDTH-1:0]    push_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PtrLast) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight    = IW'(stb_q) + IW'(out_q) + IW'(fifo_cnt_q);
    req_ready_o = wb_rst_n_i && (state_q != StAbort) &&
                  (inflight < IW'(MAX_OUTSTANDING)) && (!stb_q || !wb_stall_i);
    accept      = req_valid_i && req_ready_o;
    issue       = stb_q && !wb_stall_i;
    // With nothing outstanding, only a transfer issuing this very cycle can be retired.
    head_we     = (out_q == '0) ? we_q : ord_we_q[ord_rptr_q];
    retire      = (state_q == StActive) && (wb_ack_i || wb_error_i) &&
                  ((out_q != '0) || issue);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == StActive) &&
                  (out_q != '0) && (tmo_q == TmoLimit);
    go_abort    = (retire && wb_error_i) || timeout_hit;
    pop         = rsp_valid_o && rsp_ready_i;
  end

  always_comb begin
    state_d   = state_q;
    stb_d     = stb_q;
    out_d     = out_q;
    tmo_d     = '0;
    push      = 1'b0;
    push_err  = 1'b1;
    push_data = '1;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          stb_d   = 1'b1;
          state_d = StActive;
        end
      end
      StActive: begin
        out_d = out_q + CW'(issue) - CW'(retire);
        if (retire) begin
          push      = 1'b1;
          push_err  = wb_error_i;
          push_data = wb_error_i ? '1 : (head_we ? '0 : wb_data_i);
        end
        if (accept) begin
          stb_d = 1'b1;
        end else if (issue) begin
          stb_d = 1'b0;
        end
        if (!(wb_ack_i || wb_error_i || issue) && (out_q != '0) && (tmo_q != TmoLimit)) begin
          tmo_d = tmo_q + TW'(1);
        end
        if (go_abort) begin
          // A strobe that never issued and a request accepted this cycle both become
          // error responses flushed from ABORT.
          state_d = StAbort;
          stb_d   = 1'b0;
          out_d   = out_d + CW'(stb_q && !issue) + CW'(accept);
          tmo_d   = '0;
        end else if (!stb_q && (out_q == '0) && !accept) begin
          state_d = StIdle;
        end
      end
      StAbort: begin
        if (out_q != '0) begin
          push  = 1'b1;
          out_d = out_q - CW'(1);
        end
        if (out_q <= CW'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= StIdle;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      data_q  <= '1;
      out_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      out_q   <= out_d;
      tmo_q   <= tmo_d;
      if (accept) begin
        we_q   <= req_write_i;
        sel_q  <= req_byte_select_i;
        adr_q  <= req_address_i;
        data_q <= req_data_i;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_data_q[i] <= '0;
        fifo_err_q[i]  <= 1'b0;
      end
      fifo_wptr_q <= '0;
      fifo_rptr_q <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_data_q[fifo_wptr_q] <= push_data;
        fifo_err_q[fifo_wptr_q]  <= push_err;
        fifo_wptr_q              <= ptr_inc(fifo_wptr_q);
      end
      if (pop) begin
        fifo_rptr_q <= ptr_inc(fifo_rptr_q);
      end
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        ord_we_q[i] <= 1'b0;
      end
      ord_wptr_q <= '0;
      ord_rptr_q <= '0;
    end else if (state_d == StAbort) begin
      // Kinds are irrelevant once aborting; every remaining transfer ends as an error.
      ord_wptr_q <= '0;
      ord_rptr_q <= '0;
    end else begin
      if (issue) begin
        ord_we_q[ord_wptr_q] <= we_q;
        ord_wptr_q           <= ptr_inc(ord_wptr_q);
      end
      if (retire) begin
        ord_rptr_q <= ptr_inc(ord_rptr_q);
      end
    end
  end

  assign wb_cyc_o    = (state_q == StActive) && (stb_q || (out_q != '0));
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_adr_o    = adr_q;
  assign wb_data_o   = data_q;
  assign rsp_valid_o = (fifo_cnt_q != '0);
  assign rsp_data_o  = fifo_data_q[fifo_rptr_q];
  assign rsp_error_o = fifo_err_q[fifo_rptr_q];
  assign busy_o      = (state_q != StIdle) || (fifo_cnt_q != '0);
  assign timeout_o   = timeout_hit;

endmodule

// File: tb/tb_core_wb_pipelined_master.sv
// Bench for core_wb_pipelined_master: a transaction-level model of requester, Wishbone
// slave and expected response stream, driven by directed phases and random traffic.
module tb_core_wb_pipelined_master;
  localparam int unsigned AW = 28, DW = 32, SW = 4, MAXO = 4, TMO = 8;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_n_i;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [SW-1:0] wb_sel_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_data_o;
  logic          wb_ack_i, wb_stall_i, wb_error_i;
  logic [DW-1:0] wb_data_i;
  logic          req_valid_i, req_ready_o, req_write_i;
  logic [AW-1:0] req_address_i;
  logic [SW-1:0] req_byte_select_i;
  logic [DW-1:0] req_data_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_error_o, busy_o, timeout_o;
  logic [DW-1:0] rsp_data_o;

  core_wb_pipelined_master #(
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .MAX_OUTSTANDING(MAXO),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .wb_clk_i         (wb_clk_i),
    .wb_rst_n_i       (wb_rst_n_i),
    .wb_cyc_o         (wb_cyc_o),
    .wb_stb_o         (wb_stb_o),
    .wb_we_o          (wb_we_o),
    .wb_sel_o         (wb_sel_o),
    .wb_adr_o         (wb_adr_o),
    .wb_data_o        (wb_data_o),
    .wb_ack_i         (wb_ack_i),
    .wb_stall_i       (wb_stall_i),
    .wb_error_i       (wb_error_i),
    .wb_data_i        (wb_data_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_write_i      (req_write_i),
    .req_address_i    (req_address_i),
    .req_byte_select_i(req_byte_select_i),
    .req_data_i       (req_data_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_data_o       (rsp_data_o),
    .rsp_error_o      (rsp_error_o),
    .busy_o           (busy_o),
    .timeout_o        (timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct packed {logic we; logic [AW-1:0] adr; logic [SW-1:0] sel; logic [DW-1:0] data;} req_t;
  typedef struct {logic we; logic [DW-1:0] rdata; int dly;} slv_t;
  typedef struct packed {logic [DW-1:0] d; logic e;} rsp_t;

  req_t stim_q[$];  // requests still to present
  req_t iss_q[$];   // accepted, not yet issued on the bus
  slv_t slv_q[$];   // issued, awaiting slave ack
  rsp_t exp_q[$];   // expected responses in order

  int n_checks = 0, n_errors = 0;
  int acc_cnt, pop_cnt, idle_cnt, to_count;
  int fixed_dly, dly_max;
  int unsigned stall_pct, rdy_pct;
  bit normal, mute, err_next, force_rd_en;
  logic [DW-1:0] force_rd;
  req_t cur_req;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.we   = 1'($urandom_range(0, 1));
    r.adr  = AW'($urandom);
    r.sel  = SW'($urandom_range(1, 15));
    r.data = $urandom;
    return r;
  endfunction

  // Everything not yet retired returns as an all-ones error response.
  task automatic flush();
    rsp_t x;
    x.d = '1;
    x.e = 1'b1;
    repeat (slv_q.size() + iss_q.size()) exp_q.push_back(x);
    slv_q.delete();
    iss_q.delete();
  endtask

  task automatic cycle();
    logic acc, iss, pop, to_exp;
    req_t r;
    slv_t s;
    rsp_t x;
    @(negedge wb_clk_i);
    acc    = req_valid_i && req_ready_o;
    iss    = wb_stb_o && !wb_stall_i;
    pop    = rsp_valid_o && rsp_ready_i;
    to_exp = (slv_q.size() > 0) && (idle_cnt == int'(TMO));
    chk("stb", wb_stb_o, iss_q.size() > 0);
    chk("cyc", wb_cyc_o, (iss_q.size() > 0) || (slv_q.size() > 0));
    chk("timeout", timeout_o, to_exp);
    if (normal) begin
      chk("req_ready", req_ready_o,
          ((acc_cnt - pop_cnt) < int'(MAXO)) && !(wb_stb_o && wb_stall_i));
      chk("rsp_valid", rsp_valid_o, exp_q.size() > 0);
    end
    if (iss_q.size() > 0) begin
      r = iss_q[0];
      chk("adr", wb_adr_o, r.adr);
      chk("we", wb_we_o, r.we);
      chk("sel", wb_sel_o, r.sel);
      if (r.we) chk("wdata", wb_data_o, r.data);
      if (iss) begin
        void'(iss_q.pop_front());
        s.we    = r.we;
        s.rdata = force_rd_en ? force_rd : $urandom;
        s.dly   = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, dly_max));
        force_rd_en = 1'b0;
        slv_q.push_back(s);
      end
    end
    if (acc) begin
      iss_q.push_back(cur_req);
      acc_cnt++;
    end
    if (pop) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", rsp_valid_o, 0);
      end else begin
        x = exp_q.pop_front();
        chk("rsp_data", rsp_data_o, x.d);
        chk("rsp_error", rsp_error_o, x.e);
      end
      pop_cnt++;
    end
    if ((wb_ack_i || wb_error_i) && slv_q.size() > 0) begin
      s = slv_q.pop_front();
      if (wb_error_i) begin
        x.d = '1;
        x.e = 1'b1;
        exp_q.push_back(x);
        flush();
      end else begin
        x.d = s.we ? '0 : s.rdata;
        x.e = 1'b0;
        exp_q.push_back(x);
      end
    end
    if (to_exp) begin
      to_count++;
      flush();
    end
    if (wb_ack_i || wb_error_i || iss) idle_cnt = 0;
    else if (slv_q.size() > 0) idle_cnt++;
    else idle_cnt = 0;

    @(posedge wb_clk_i);
    #1;
    if (acc || !req_valid_i) begin
      if (stim_q.size() > 0) begin
        cur_req           = stim_q.pop_front();
        req_valid_i       = 1'b1;
        req_write_i       = cur_req.we;
        req_address_i     = cur_req.adr;
        req_byte_select_i = cur_req.sel;
        req_data_i        = cur_req.data;
      end else begin
        req_valid_i = 1'b0;
      end
    end
    rsp_ready_i = ($urandom_range(0, 99) < rdy_pct);
    wb_stall_i  = ($urandom_range(0, 99) < stall_pct);
    wb_ack_i    = 1'b0;
    wb_error_i  = 1'b0;
    wb_data_i   = $urandom;
    if (!mute && slv_q.size() > 0) begin
      if (slv_q[0].dly == 0) begin
        if (err_next) begin
          wb_error_i = 1'b1;
          wb_ack_i   = 1'($urandom_range(0, 1));
          err_next   = 1'b0;
        end else begin
          wb_ack_i  = 1'b1;
          wb_data_i = slv_q[0].rdata;
        end
      end else begin
        slv_q[0].dly = slv_q[0].dly - 1;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((stim_q.size() + iss_q.size() + slv_q.size() + exp_q.size() != 0 ||
            req_valid_i || busy_o) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_done", stim_q.size() + iss_q.size() + slv_q.size() + exp_q.size(), 0);
    chk("busy_idle", busy_o, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cyc"}, wb_cyc_o, 0);
    chk({tag, "_stb"}, wb_stb_o, 0);
    chk({tag, "_we"}, wb_we_o, 0);
    chk({tag, "_sel"}, wb_sel_o, 0);
    chk({tag, "_adr"}, wb_adr_o, 0);
    chk({tag, "_wdata"}, wb_data_o, 32'hFFFF_FFFF);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_req_ready"}, req_ready_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_timeout"}, timeout_o, 0);
  endtask

  initial begin
    req_t r;
    wb_rst_n_i = 1'b0;
    req_valid_i = 1'b0; req_write_i = 1'b0; req_address_i = '0;
    req_byte_select_i = '0; req_data_i = '0; rsp_ready_i = 1'b0;
    wb_ack_i = 1'b0; wb_stall_i = 1'b0; wb_error_i = 1'b0; wb_data_i = '0;
    acc_cnt = 0; pop_cnt = 0; idle_cnt = 0; to_count = 0;
    fixed_dly = -1; dly_max = 3; stall_pct = 0; rdy_pct = 100;
    normal = 1'b1; mute = 1'b0; err_next = 1'b0; force_rd_en = 1'b0; force_rd = '0;
    cur_req = '0;
    repeat (3) @(negedge wb_clk_i);
    check_reset_outputs("reset");
    #2 wb_rst_n_i = 1'b1;
    @(posedge wb_clk_i);
    #1;

    // Single read at 0x10, ack two cycles after strobe.
    fixed_dly = 1; force_rd_en = 1'b1; force_rd = 32'hDEAD_BEEF;
    r.we = 1'b0; r.adr = 28'h000_0010; r.sel = 4'hF; r.data = '0;
    stim_q.push_back(r);
    drain(40);

    // Four back-to-back writes, ack next cycle.
    fixed_dly = 0;
    for (int i = 0; i < 4; i++) begin
      r = rand_req();
      r.we = 1'b1;
      stim_q.push_back(r);
    end
    drain(40);

    // Three reads under random stall.
    fixed_dly = -1; stall_pct = 50;
    for (int i = 0; i < 3; i++) begin
      r = rand_req();
      r.we = 1'b0;
      stim_q.push_back(r);
    end
    drain(60);

    // Responses held back: the fifth request must wait for a pop.
    stall_pct = 0; fixed_dly = 0; rdy_pct = 0;
    for (int i = 0; i < 5; i++) begin
      r = rand_req();
      r.we = 1'b0;
      stim_q.push_back(r);
    end
    repeat (12) cycle();
    chk("fifth_blocked", req_ready_o, 0);
    chk("fifo_full_valid", rsp_valid_o, 1);
    rdy_pct = 100;
    drain(60);

    // Random traffic.
    fixed_dly = -1; dly_max = 3; stall_pct = 25; rdy_pct = 70;
    for (int i = 0; i < 250; i++) stim_q.push_back(rand_req());
    drain(3000);

    // Bus error on the first of three reads.
    normal = 1'b0; stall_pct = 0; rdy_pct = 100; fixed_dly = 2; err_next = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r = rand_req();
      r.we = 1'b0;
      stim_q.push_back(r);
    end
    drain(60);
    chk("error_consumed", err_next, 0);

    // Slave never acks: timeout abort.
    mute = 1'b1; fixed_dly = 0; to_count = 0;
    r = rand_req();
    r.we = 1'b1;
    stim_q.push_back(r);
    drain(60);
    chk("timeout_count", to_count, 1);
    mute = 1'b0; normal = 1'b1;

    // Reset in the middle of a burst.
    fixed_dly = -1; stall_pct = 20; rdy_pct = 0;
    for (int i = 0; i < 6; i++) stim_q.push_back(rand_req());
    repeat (4) cycle();
    #1 wb_rst_n_i = 1'b0;
    #1 check_reset_outputs("midreset");
    stim_q.delete(); iss_q.delete(); slv_q.delete(); exp_q.delete();
    acc_cnt = 0; pop_cnt = 0; idle_cnt = 0;
    req_valid_i = 1'b0; wb_ack_i = 1'b0; wb_error_i = 1'b0; wb_stall_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    #2 wb_rst_n_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    rdy_pct = 80;
    for (int i = 0; i < 20; i++) stim_q.push_back(rand_req());
    drain(400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
